// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and control bundle for the pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_ST_RUN     = 2'd0,
    CTRL_ST_FLUSH   = 2'd1,
    CTRL_ST_MC_WAIT = 2'd2,
    CTRL_ST_INT     = 2'd3
  } ctrl_state_e;

  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic [4:0]  ZERO_REG_ADDR = 5'h0;
  localparam int          FLUSH_CNT_W   = 3;

  typedef struct packed {
    logic        hold_pc;
    logic        hold_if_id;
    logic        hold_id_ex;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        jump;
    logic        int_ack;
    logic [31:0] jump_addr;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_IDLE = '{default: '0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - decode/EX hazard inputs and pipeline control outputs (PIPE_CTRL_PERF_CNT_EN adds counters)
interface pipe_ctrl_if
`ifdef PIPE_CTRL_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0]  id_reg1_rd_addr_i;
  logic [4:0]  id_reg2_rd_addr_i;
  logic        ex_mem_rd_flag_i;
  logic [4:0]  ex_reg_wr_addr_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_busy_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        int_ack_o;
  logic [1:0]  state_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic             clr_cnt_i;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
`endif

  modport master (
    output id_reg1_rd_addr_i, id_reg2_rd_addr_i, ex_mem_rd_flag_i, ex_reg_wr_addr_i,
           ex_jump_flag_i, ex_jump_addr_i, ex_busy_i, int_req_i, int_addr_i,
`ifdef PIPE_CTRL_PERF_CNT_EN
           clr_cnt_i,
    input  stall_cnt_o, flush_cnt_o,
`endif
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
           jump_o, jump_addr_o, int_ack_o, state_o
  );

  modport slave (
    input  id_reg1_rd_addr_i, id_reg2_rd_addr_i, ex_mem_rd_flag_i, ex_reg_wr_addr_i,
           ex_jump_flag_i, ex_jump_addr_i, ex_busy_i, int_req_i, int_addr_i,
`ifdef PIPE_CTRL_PERF_CNT_EN
           clr_cnt_i,
    output stall_cnt_o, flush_cnt_o,
`endif
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
           jump_o, jump_addr_o, int_ack_o, state_o
  );

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// rtl/pipe_ctrl_perf_cnt.sv - wrapping stall and flush cycle counters with synchronous clear
module pipe_ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Clear takes precedence over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard/flow controller for the IF/ID/EX core; PIPE_CTRL_PERF_CNT_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
`ifdef PIPE_CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  ctrl_if
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e            r_state;
  ctrl_state_e            w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_cnt;
  logic [FLUSH_CNT_W-1:0] w_cnt_nxt;
  logic                   w_load_use;
  logic                   w_int_take;
  ctrl_out_t              w_out;
  ctrl_out_t              w_out_gated;

  assign w_load_use = ctrl_if.ex_mem_rd_flag_i
                   && (ctrl_if.ex_reg_wr_addr_i != ZERO_REG_ADDR)
                   && ((ctrl_if.ex_reg_wr_addr_i == ctrl_if.id_reg1_rd_addr_i)
                    || (ctrl_if.ex_reg_wr_addr_i == ctrl_if.id_reg2_rd_addr_i));

  assign w_int_take = ctrl_if.int_req_i && !ctrl_if.ex_busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CTRL_ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CTRL_ST_RUN: begin
        if (w_int_take) begin
          w_state_nxt = CTRL_ST_INT;
        end else if (ctrl_if.ex_jump_flag_i) begin
          w_cnt_nxt   = FLUSH_LOAD;
          w_state_nxt = (FLUSH_LOAD != '0) ? CTRL_ST_FLUSH : CTRL_ST_RUN;
        end else if (ctrl_if.ex_busy_i) begin
          w_state_nxt = CTRL_ST_MC_WAIT;
        end
      end
      // r_cnt counts the flush cycles still owed including this one.
      CTRL_ST_FLUSH: begin
        if (r_cnt <= FLUSH_CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = CTRL_ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      CTRL_ST_MC_WAIT: begin
        if (!ctrl_if.ex_busy_i) w_state_nxt = CTRL_ST_RUN;
      end
      CTRL_ST_INT: begin
        w_state_nxt = CTRL_ST_RUN;
      end
      default: begin
        w_state_nxt = CTRL_ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_out = CTRL_OUT_IDLE;
    case (r_state)
      CTRL_ST_RUN: begin
        if (w_int_take) begin
          w_out.jump        = 1'b1;
          w_out.jump_addr   = ctrl_if.int_addr_i;
          w_out.flush_if_id = 1'b1;
          w_out.flush_id_ex = 1'b1;
          w_out.int_ack     = 1'b1;
        end else if (ctrl_if.ex_jump_flag_i) begin
          w_out.jump        = 1'b1;
          w_out.jump_addr   = ctrl_if.ex_jump_addr_i;
          w_out.flush_if_id = 1'b1;
          w_out.flush_id_ex = 1'b1;
        end else if (ctrl_if.ex_busy_i) begin
          w_out.hold_pc    = 1'b1;
          w_out.hold_if_id = 1'b1;
          w_out.hold_id_ex = 1'b1;
        end else if (w_load_use) begin
          w_out.hold_pc     = 1'b1;
          w_out.hold_if_id  = 1'b1;
          w_out.flush_id_ex = 1'b1;
        end
      end
      CTRL_ST_FLUSH, CTRL_ST_INT: begin
        w_out.flush_if_id = 1'b1;
        w_out.flush_id_ex = 1'b1;
      end
      CTRL_ST_MC_WAIT: begin
        w_out.hold_pc    = ctrl_if.ex_busy_i;
        w_out.hold_if_id = ctrl_if.ex_busy_i;
        w_out.hold_id_ex = ctrl_if.ex_busy_i;
      end
      default: w_out = CTRL_OUT_IDLE;
    endcase
  end

  // Outputs are combinational, so reset must force them quiet without waiting for a clock.
  assign w_out_gated = rst_n ? w_out : CTRL_OUT_IDLE;

  assign ctrl_if.hold_pc_o     = w_out_gated.hold_pc;
  assign ctrl_if.hold_if_id_o  = w_out_gated.hold_if_id;
  assign ctrl_if.hold_id_ex_o  = w_out_gated.hold_id_ex;
  assign ctrl_if.flush_if_id_o = w_out_gated.flush_if_id;
  assign ctrl_if.flush_id_ex_o = w_out_gated.flush_id_ex;
  assign ctrl_if.jump_o        = w_out_gated.jump;
  assign ctrl_if.jump_addr_o   = w_out_gated.jump_addr;
  assign ctrl_if.int_ack_o     = w_out_gated.int_ack;
  assign ctrl_if.state_o       = r_state;

`ifdef PIPE_CTRL_PERF_CNT_EN
  pipe_ctrl_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (ctrl_if.clr_cnt_i),
    .i_stall     (w_out_gated.hold_pc),
    .i_flush     (w_out_gated.flush_id_ex),
    .o_stall_cnt (ctrl_if.stall_cnt_o),
    .o_flush_cnt (ctrl_if.flush_cnt_o)
  );
`endif

endmodule
